pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Watches the ID operands, the EX load/redirect
//  status, the data-memory handshake and WFI, and drives per-stage hold/flush strobes to IF, IF/ID, ID/EX, EX/MEM.
//  Replaces scattered stall/flush logic. Sits beside the ID stage: ID's stall/flush inputs come from here.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles ifid_flush_o is held after an EX redirect (fetch refill latency), range 1..15
//  MEM_TIMEOUT   16  max wait cycles for gnt+rvalid before abandoning the access, range 2..255
// PORTS
//  clk               in   1  clock, all state on rising edge
//  rst               in   1  reset, asynchronous, active-high
//  ID_rs1_add_i      in   5  rs1 address of instr in ID
//  ID_rs2_add_i      in   5  rs2 address of instr in ID
//  ID_wfi_insn_i     in   1  instr in ID is WFI
//  EX_rd_add_i       in   5  rd of instr in EX
//  EX_RD_en_i        in   1  instr in EX is a load
//  EX_pc_sel_i       in   1  EX resolved taken branch/jump (redirect)
//  MEM_data_req_i    in   1  data-memory request from MEM
//  MEM_data_gnt_i    in   1  data-memory grant
//  MEM_data_rvalid_i in   1  data-memory response valid
//  irq_pending_i     in   1  enabled interrupt pending
//  pc_hold_o         out  1  PC keeps value
//  ifid_hold_o       out  1  IF/ID register keeps value
//  idex_hold_o       out  1  ID/EX register keeps value (ID stall input)
//  exmem_hold_o      out  1  EX/MEM register keeps value
//  ifid_flush_o      out  1  IF/ID loaded with NOP
//  idex_flush_o      out  1  ID/EX loaded with bubble (ID flush input)
//  sleep_o           out  1  core sleeping in WFI
//  mem_timeout_o     out  1  1-cycle pulse: access abandoned
//  state_o           out  3  FSM state: RUN=0 FLUSH=1 WAIT_GNT=2 WAIT_RVAL=3 SLEEP=4
// BEHAVIOUR
//  - Registered: state, flush counter (4b), timeout counter (8b). Strobes: Mealy of state+inputs, same-cycle.
//  - rst high: state=RUN, counters=0, every output 0 (forced, regardless of inputs). Deassert: RUN next edge.
//  - Precedence in RUN: mem > redirect > load-use > WFI. Lower-priority events in same cycle are ignored.
//  - mem (RUN): MEM_data_req_i && !(gnt && rvalid) -> pc/ifid/idex/exmem_hold=1, no flush;
//    next = gnt ? WAIT_RVAL : WAIT_GNT; timeout ctr=1. req with gnt&&rvalid same cycle -> no hold, stay RUN.
//  - WAIT_GNT: all holds=1; gnt&&rvalid -> holds 0 this cycle, RUN; gnt only -> WAIT_RVAL.
//  - WAIT_RVAL: rvalid -> holds 0 this cycle, RUN; else all holds=1.
//  - Timeout: ctr increments each WAIT_* cycle; in the cycle ctr==MEM_TIMEOUT with no completion:
//    mem_timeout_o=1, holds 0, -> RUN. EX redirect ignored in WAIT_*; EX is held, so it is seen in RUN after.
//  - redirect (RUN, EX_pc_sel_i): ifid_flush_o=1, idex_flush_o=1 this cycle. FLUSH_CYCLES==1 -> stay RUN;
//    else -> FLUSH, ctr=FLUSH_CYCLES-1. FLUSH: ifid_flush_o=1 only; ctr-- ; ctr==1 -> RUN.
//    New redirect in FLUSH: both flushes, ctr reload FLUSH_CYCLES-1. mem req in FLUSH: mem rules apply.
//  - load-use (RUN): EX_RD_en_i && EX_rd_add_i!=0 && EX_rd_add_i in {rs1,rs2} -> pc_hold, ifid_hold,
//    idex_flush =1 for that cycle only; state stays RUN. x0 never stalls.
//  - WFI (RUN): ID_wfi_insn_i && !irq_pending_i -> pc_hold, ifid_hold, idex_flush=1; -> SLEEP.
//    WFI with irq pending -> treated as NOP, no stall. SLEEP: sleep_o=1, same three strobes;
//    irq_pending_i -> RUN next edge (strobes still asserted that cycle). sleep_o is Moore (state==SLEEP).
//  - hold and flush of the same register are never both 1. Illegal state encodings -> RUN.
// TESTING
//  1 EX_RD_en=1,EX_rd=5,ID_rs1=5 at t -> pc_hold,ifid_hold,idex_flush=1 at t only; repeat with EX_rd=0 -> none.
//  2 FLUSH_CYCLES=3, EX_pc_sel at t -> ifid+idex_flush at t, ifid_flush only t+1,t+2; state_o=0 at t+3.
//  3 req at t, gnt at t+2, rvalid t+4 -> all holds 1 t..t+3, 0 at t+4; state_o 2,2,3,3,0.
//  4 MEM_TIMEOUT=8, req, no gnt -> holds t..t+6, mem_timeout_o=1 at t+7, state_o=0 at t+8.
//  5 WFI, irq=0 at t -> sleep_o=1 t+1..; irq at t+5 -> state RUN at t+6; WFI with irq=1 -> no strobes.
//  6 rst pulsed mid-FLUSH and mid-WAIT_GNT -> outputs 0 immediately (async), state_o=0; redirect+req same cycle -> mem wins.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave). Signal names match the sequencer's port list.
interface pipeline_hazard_ctrl_if;
  logic [4:0] ID_rs1_add_i;
  logic [4:0] ID_rs2_add_i;
  logic       ID_wfi_insn_i;
  logic [4:0] EX_rd_add_i;
  logic       EX_RD_en_i;
  logic       EX_pc_sel_i;
  // Data-memory handshake: MEM raises req; the access is complete once gnt
  // and rvalid have both been seen (same cycle, or gnt first then rvalid).
  logic       MEM_data_req_i;
  logic       MEM_data_gnt_i;
  logic       MEM_data_rvalid_i;
  logic       irq_pending_i;

  logic       pc_hold_o;
  logic       ifid_hold_o;
  logic       idex_hold_o;
  logic       exmem_hold_o;
  logic       ifid_flush_o;
  logic       idex_flush_o;
  logic       sleep_o;
  logic       mem_timeout_o;
  logic [2:0] state_o;

  modport master (
    output ID_rs1_add_i, ID_rs2_add_i, ID_wfi_insn_i, EX_rd_add_i, EX_RD_en_i,
           EX_pc_sel_i, MEM_data_req_i, MEM_data_gnt_i, MEM_data_rvalid_i,
           irq_pending_i,
    input  pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o, ifid_flush_o,
           idex_flush_o, sleep_o, mem_timeout_o, state_o
  );

  modport slave (
    input  ID_rs1_add_i, ID_rs2_add_i, ID_wfi_insn_i, EX_rd_add_i, EX_RD_en_i,
           EX_pc_sel_i, MEM_data_req_i, MEM_data_gnt_i, MEM_data_rvalid_i,
           irq_pending_i,
    output pc_hold_o, ifid_hold_o, idex_hold_o, exmem_hold_o, ifid_flush_o,
           idex_flush_o, sleep_o, mem_timeout_o, state_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory wait,
// branch-redirect flush, load-use stall and WFI sleep, with same-cycle strobes.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_hazard_ctrl_if.slave        hz
);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_WAIT_GNT  = 3'd2,
    ST_WAIT_RVAL = 3'd3,
    ST_SLEEP     = 3'd4
  } state_e;

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TMO_LAST     = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic mem_stall, mem_both, load_use, wfi_stall;
  logic pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic ifid_flush, idex_flush, mem_timeout;

  assign mem_both  = hz.MEM_data_gnt_i && hz.MEM_data_rvalid_i;
  assign mem_stall = hz.MEM_data_req_i && !mem_both;
  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use  = hz.EX_RD_en_i && (hz.EX_rd_add_i != 5'd0) &&
                     ((hz.EX_rd_add_i == hz.ID_rs1_add_i) ||
                      (hz.EX_rd_add_i == hz.ID_rs2_add_i));
  assign wfi_stall = hz.ID_wfi_insn_i && !hz.irq_pending_i;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mem_timeout = 1'b0;

    unique case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (mem_stall) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
          tmo_cnt_d  = 8'd1;
          state_d    = hz.MEM_data_gnt_i ? ST_WAIT_RVAL : ST_WAIT_GNT;
        end else if (hz.EX_pc_sel_i) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          flush_cnt_d = FLUSH_RELOAD;
          state_d     = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end else if (state_q == ST_FLUSH) begin
          // Remaining refill cycles only squash fetch; ID already holds a NOP.
          ifid_flush  = 1'b1;
          flush_cnt_d = flush_cnt_q - 4'd1;
          if (flush_cnt_q <= 4'd1) state_d = ST_RUN;
        end else if (load_use) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
        end else if (wfi_stall) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
          state_d    = ST_SLEEP;
        end
      end

      ST_WAIT_GNT, ST_WAIT_RVAL: begin
        if ((state_q == ST_WAIT_GNT) ? mem_both : hz.MEM_data_rvalid_i) begin
          state_d = ST_RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          mem_timeout = 1'b1;
          state_d     = ST_RUN;
        end else begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
          tmo_cnt_d  = tmo_cnt_q + 8'd1;
          if (state_q == ST_WAIT_GNT && hz.MEM_data_gnt_i) state_d = ST_WAIT_RVAL;
        end
      end

      ST_SLEEP: begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
        if (hz.irq_pending_i) state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 4'd0;
      tmo_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  // Strobes are combinational, so reset must mask them directly.
  assign hz.pc_hold_o     = !rst && pc_hold;
  assign hz.ifid_hold_o   = !rst && ifid_hold;
  assign hz.idex_hold_o   = !rst && idex_hold;
  assign hz.exmem_hold_o  = !rst && exmem_hold;
  assign hz.ifid_flush_o  = !rst && ifid_flush;
  assign hz.idex_flush_o  = !rst && idex_flush;
  assign hz.mem_timeout_o = !rst && mem_timeout;
  assign hz.sleep_o       = !rst && (state_q == ST_SLEEP);
  assign hz.state_o       = rst ? 3'd0 : state_q;

endmodule
